// File: rtl/friscv_cache_wr_upsizer.sv
// rtl/friscv_cache_wr_upsizer.sv - XLEN-to-AXI_DATA_W single-beat write upsizer with AW/W join and B buffer
module friscv_cache_wr_upsizer #(
  parameter int XLEN        = 32,
  parameter int AXI_ADDR_W  = 32,
  parameter int AXI_ID_W    = 8,
  parameter int AXI_DATA_W  = 128,
  parameter int OSTDREQ_NUM = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  // slave write address
  input  logic                    slv_awvalid,
  output logic                    slv_awready,
  input  logic [AXI_ADDR_W-1:0]   slv_awaddr,
  input  logic [2:0]              slv_awprot,
  input  logic [AXI_ID_W-1:0]     slv_awid,
  // slave write data
  input  logic                    slv_wvalid,
  output logic                    slv_wready,
  input  logic [XLEN-1:0]         slv_wdata,
  input  logic [XLEN/8-1:0]       slv_wstrb,
  // slave write response
  output logic                    slv_bvalid,
  input  logic                    slv_bready,
  output logic [AXI_ID_W-1:0]     slv_bid,
  output logic [1:0]              slv_bresp,
  // master write address
  output logic                    mst_awvalid,
  input  logic                    mst_awready,
  output logic [AXI_ADDR_W-1:0]   mst_awaddr,
  output logic [2:0]              mst_awprot,
  output logic [AXI_ID_W-1:0]     mst_awid,
  // master write data
  output logic                    mst_wvalid,
  input  logic                    mst_wready,
  output logic [AXI_DATA_W-1:0]   mst_wdata,
  output logic [AXI_DATA_W/8-1:0] mst_wstrb,
  output logic                    mst_wlast,
  // master write response
  input  logic                    mst_bvalid,
  output logic                    mst_bready,
  input  logic [AXI_ID_W-1:0]     mst_bid,
  input  logic [1:0]              mst_bresp
);

  localparam int SLV_STRB_W = XLEN / 8;
  localparam int MST_STRB_W = AXI_DATA_W / 8;
  localparam int RATIO      = AXI_DATA_W / XLEN;
  // Address bits selecting the byte offset of the XLEN lane inside the wide beat;
  // zero when the widths match so the strobes stay in place.
  localparam logic [AXI_ADDR_W-1:0] LANE_BYTE_MASK = AXI_ADDR_W'((RATIO - 1) * SLV_STRB_W);
  localparam logic [7:0]            OSTD_MAX       = 8'(OSTDREQ_NUM);

  // entry registers
  logic                    aw_full_q, aw_full_d;
  logic [AXI_ADDR_W-1:0]   aw_addr_q, aw_addr_d;
  logic [2:0]              aw_prot_q, aw_prot_d;
  logic [AXI_ID_W-1:0]     aw_id_q, aw_id_d;
  logic                    w_full_q, w_full_d;
  logic [XLEN-1:0]         w_data_q, w_data_d;
  logic [SLV_STRB_W-1:0]   w_strb_q, w_strb_d;
  // master output registers
  logic                    mst_awvalid_q, mst_awvalid_d;
  logic [AXI_ADDR_W-1:0]   mst_awaddr_q, mst_awaddr_d;
  logic [2:0]              mst_awprot_q, mst_awprot_d;
  logic [AXI_ID_W-1:0]     mst_awid_q, mst_awid_d;
  logic                    mst_wvalid_q, mst_wvalid_d;
  logic [AXI_DATA_W-1:0]   mst_wdata_q, mst_wdata_d;
  logic [MST_STRB_W-1:0]   mst_wstrb_q, mst_wstrb_d;
  // response buffer and outstanding counter
  logic                    b_full_q, b_full_d;
  logic [AXI_ID_W-1:0]     b_id_q, b_id_d;
  logic [1:0]              b_resp_q, b_resp_d;
  logic [7:0]              ostd_cnt_q, ostd_cnt_d;

  logic                    join_w;
  logic                    aw_hs;
  logic                    w_hs;
  logic                    b_load;
  logic                    b_unload;
  logic [AXI_ADDR_W-1:0]   lane_byte;

  // Handshakes, AW/W join, lane steering and next-state for every register
  always_comb begin
    join_w      = aw_full_q & w_full_q & ~mst_awvalid_q & ~mst_wvalid_q;
    slv_awready = (~aw_full_q | join_w) & (ostd_cnt_q < OSTD_MAX);
    slv_wready  = ~w_full_q | join_w;
    mst_bready  = ~b_full_q | slv_bready;
    aw_hs       = slv_awvalid & slv_awready;
    w_hs        = slv_wvalid & slv_wready;
    b_load      = mst_bvalid & mst_bready;
    b_unload    = b_full_q & slv_bready;
    lane_byte   = aw_addr_q & LANE_BYTE_MASK;

    // Entries empty on join unless a new request lands in the same cycle.
    aw_full_d = aw_hs | (aw_full_q & ~join_w);
    aw_addr_d = aw_hs ? slv_awaddr : aw_addr_q;
    aw_prot_d = aw_hs ? slv_awprot : aw_prot_q;
    aw_id_d   = aw_hs ? slv_awid   : aw_id_q;
    w_full_d  = w_hs | (w_full_q & ~join_w);
    w_data_d  = w_hs ? slv_wdata : w_data_q;
    w_strb_d  = w_hs ? slv_wstrb : w_strb_q;

    // Outputs only load when both channels are idle, so a stalled beat stays stable.
    mst_awvalid_d = join_w | (mst_awvalid_q & ~mst_awready);
    mst_wvalid_d  = join_w | (mst_wvalid_q & ~mst_wready);
    mst_awaddr_d  = join_w ? aw_addr_q : mst_awaddr_q;
    mst_awprot_d  = join_w ? aw_prot_q : mst_awprot_q;
    mst_awid_d    = join_w ? aw_id_q   : mst_awid_q;
    mst_wdata_d   = join_w ? {RATIO{w_data_q}} : mst_wdata_q;
    mst_wstrb_d   = join_w ? (MST_STRB_W'(w_strb_q) << lane_byte) : mst_wstrb_q;

    // A load and unload together keeps the buffer full with the newer response.
    b_full_d = b_load | (b_full_q & ~slv_bready);
    b_id_d   = b_load ? mst_bid   : b_id_q;
    b_resp_d = b_load ? mst_bresp : b_resp_q;

    ostd_cnt_d = ostd_cnt_q;
    if (aw_hs && !b_unload) begin
      ostd_cnt_d = ostd_cnt_q + 8'd1;
    end else if (!aw_hs && b_unload) begin
      ostd_cnt_d = ostd_cnt_q - 8'd1;
    end
  end

  // State registers; reset drops every in-flight request
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aw_full_q     <= 1'b0;
      aw_addr_q     <= '0;
      aw_prot_q     <= '0;
      aw_id_q       <= '0;
      w_full_q      <= 1'b0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      mst_awvalid_q <= 1'b0;
      mst_awaddr_q  <= '0;
      mst_awprot_q  <= '0;
      mst_awid_q    <= '0;
      mst_wvalid_q  <= 1'b0;
      mst_wdata_q   <= '0;
      mst_wstrb_q   <= '0;
      b_full_q      <= 1'b0;
      b_id_q        <= '0;
      b_resp_q      <= '0;
      ostd_cnt_q    <= '0;
    end else begin
      aw_full_q     <= aw_full_d;
      aw_addr_q     <= aw_addr_d;
      aw_prot_q     <= aw_prot_d;
      aw_id_q       <= aw_id_d;
      w_full_q      <= w_full_d;
      w_data_q      <= w_data_d;
      w_strb_q      <= w_strb_d;
      mst_awvalid_q <= mst_awvalid_d;
      mst_awaddr_q  <= mst_awaddr_d;
      mst_awprot_q  <= mst_awprot_d;
      mst_awid_q    <= mst_awid_d;
      mst_wvalid_q  <= mst_wvalid_d;
      mst_wdata_q   <= mst_wdata_d;
      mst_wstrb_q   <= mst_wstrb_d;
      b_full_q      <= b_full_d;
      b_id_q        <= b_id_d;
      b_resp_q      <= b_resp_d;
      ostd_cnt_q    <= ostd_cnt_d;
    end
  end

  assign mst_awvalid = mst_awvalid_q;
  assign mst_awaddr  = mst_awaddr_q;
  assign mst_awprot  = mst_awprot_q;
  assign mst_awid    = mst_awid_q;
  assign mst_wvalid  = mst_wvalid_q;
  assign mst_wdata   = mst_wdata_q;
  assign mst_wstrb   = mst_wstrb_q;
  assign mst_wlast   = 1'b1;
  assign slv_bvalid  = b_full_q;
  assign slv_bid     = b_id_q;
  assign slv_bresp   = b_resp_q;

endmodule

// File: tb/tb_friscv_cache_wr_upsizer.sv
// tb/tb_friscv_cache_wr_upsizer.sv - self-checking bench for friscv_cache_wr_upsizer
module tb_friscv_cache_wr_upsizer;

  logic         aclk, aresetn;
  logic         slv_awvalid, slv_awready;
  logic [31:0]  slv_awaddr;
  logic [2:0]   slv_awprot;
  logic [7:0]   slv_awid;
  logic         slv_wvalid, slv_wready;
  logic [31:0]  slv_wdata;
  logic [3:0]   slv_wstrb;
  logic         slv_bvalid, slv_bready;
  logic [7:0]   slv_bid;
  logic [1:0]   slv_bresp;
  logic         mst_awvalid, mst_awready;
  logic [31:0]  mst_awaddr;
  logic [2:0]   mst_awprot;
  logic [7:0]   mst_awid;
  logic         mst_wvalid, mst_wready;
  logic [127:0] mst_wdata;
  logic [15:0]  mst_wstrb;
  logic         mst_wlast;
  logic         mst_bvalid, mst_bready;
  logic [7:0]   mst_bid;
  logic [1:0]   mst_bresp;

  // narrow instance: AXI_DATA_W == XLEN
  logic         n_slv_awvalid, n_slv_awready, n_slv_wvalid, n_slv_wready;
  logic [31:0]  n_slv_awaddr, n_slv_wdata, n_mst_awaddr, n_mst_wdata;
  logic [3:0]   n_slv_wstrb, n_mst_wstrb;
  logic         n_slv_bvalid, n_mst_awvalid, n_mst_wvalid, n_mst_wlast, n_mst_bready;
  logic [7:0]   n_slv_bid, n_mst_awid;
  logic [1:0]   n_slv_bresp;
  logic [2:0]   n_mst_awprot;

  int n_checks = 0;
  int n_pass   = 0;

  friscv_cache_wr_upsizer #(.XLEN(32), .AXI_ADDR_W(32), .AXI_ID_W(8), .AXI_DATA_W(128), .OSTDREQ_NUM(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .slv_awvalid(slv_awvalid), .slv_awready(slv_awready), .slv_awaddr(slv_awaddr),
    .slv_awprot(slv_awprot), .slv_awid(slv_awid),
    .slv_wvalid(slv_wvalid), .slv_wready(slv_wready), .slv_wdata(slv_wdata), .slv_wstrb(slv_wstrb),
    .slv_bvalid(slv_bvalid), .slv_bready(slv_bready), .slv_bid(slv_bid), .slv_bresp(slv_bresp),
    .mst_awvalid(mst_awvalid), .mst_awready(mst_awready), .mst_awaddr(mst_awaddr),
    .mst_awprot(mst_awprot), .mst_awid(mst_awid),
    .mst_wvalid(mst_wvalid), .mst_wready(mst_wready), .mst_wdata(mst_wdata),
    .mst_wstrb(mst_wstrb), .mst_wlast(mst_wlast),
    .mst_bvalid(mst_bvalid), .mst_bready(mst_bready), .mst_bid(mst_bid), .mst_bresp(mst_bresp)
  );

  friscv_cache_wr_upsizer #(.XLEN(32), .AXI_ADDR_W(32), .AXI_ID_W(8), .AXI_DATA_W(32), .OSTDREQ_NUM(4)) dut_n (
    .aclk(aclk), .aresetn(aresetn),
    .slv_awvalid(n_slv_awvalid), .slv_awready(n_slv_awready), .slv_awaddr(n_slv_awaddr),
    .slv_awprot(3'd0), .slv_awid(8'h7E),
    .slv_wvalid(n_slv_wvalid), .slv_wready(n_slv_wready), .slv_wdata(n_slv_wdata), .slv_wstrb(n_slv_wstrb),
    .slv_bvalid(n_slv_bvalid), .slv_bready(1'b1), .slv_bid(n_slv_bid), .slv_bresp(n_slv_bresp),
    .mst_awvalid(n_mst_awvalid), .mst_awready(1'b1), .mst_awaddr(n_mst_awaddr),
    .mst_awprot(n_mst_awprot), .mst_awid(n_mst_awid),
    .mst_wvalid(n_mst_wvalid), .mst_wready(1'b1), .mst_wdata(n_mst_wdata),
    .mst_wstrb(n_mst_wstrb), .mst_wlast(n_mst_wlast),
    .mst_bvalid(1'b0), .mst_bready(n_mst_bready), .mst_bid(8'd0), .mst_bresp(2'd0)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  typedef struct {
    logic [31:0]  addr;
    logic [7:0]   id;
    logic [31:0]  data;
    logic [3:0]   strb;
    logic [1:0]   resp;
    logic [127:0] exp_data;
    logic [15:0]  exp_strb;
  } vec_t;

  typedef struct packed { logic [31:0] addr; logic [7:0] id; logic [2:0] prot; } aw_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; } w_t;

  vec_t vt[5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic set_aw(input logic [31:0] a, input logic [7:0] id);
    slv_awvalid = 1'b1; slv_awaddr = a; slv_awid = id; slv_awprot = 3'h2;
  endtask

  task automatic set_w(input logic [31:0] d, input logic [3:0] s);
    slv_wvalid = 1'b1; slv_wdata = d; slv_wstrb = s;
  endtask

  task automatic clr_slv;
    slv_awvalid = 1'b0; slv_wvalid = 1'b0;
  endtask

  task automatic do_reset;
    aresetn = 1'b0;
    clr_slv();
    slv_awaddr = '0; slv_awid = '0; slv_awprot = '0; slv_wdata = '0; slv_wstrb = '0;
    slv_bready = 1'b1; mst_awready = 1'b1; mst_wready = 1'b1;
    mst_bvalid = 1'b0; mst_bid = '0; mst_bresp = '0;
    n_slv_awvalid = 1'b0; n_slv_wvalid = 1'b0; n_slv_awaddr = '0; n_slv_wdata = '0; n_slv_wstrb = '0;
    tick();
    tick();
    aresetn = 1'b1;
  endtask

  // Master returns one response; with slv_bready high it is forwarded next cycle and drained the one after.
  task automatic return_b(input logic [7:0] id, input logic [1:0] resp);
    mst_bvalid = 1'b1; mst_bid = id; mst_bresp = resp;
    chk("b_mst_bready", mst_bready, 1'b1);
    tick();
    mst_bvalid = 1'b0;
    chk("b_slv_bvalid", slv_bvalid, 1'b1);
    chk("b_slv_bid", slv_bid, id);
    chk("b_slv_bresp", slv_bresp, resp);
    tick();
    chk("b_drained", slv_bvalid, 1'b0);
  endtask

  task automatic run_random(input int n);
    int sent_aw, got_b, wdone, ostd;
    bit hs_aw, hs_w, hs_mb, hs_sb;
    aw_t a;
    w_t w;
    logic [9:0] be;
    logic [127:0] ed;
    logic [15:0] es;
    aw_t exp_aw[$];
    aw_t aw_for_w[$];
    w_t exp_w[$];
    logic [7:0] mids[$];
    logic [7:0] bpend[$];
    logic [9:0] bexp[$];
    int sent_w;
    sent_aw = 0; sent_w = 0; got_b = 0; wdone = 0; ostd = 0;
    for (int cyc = 0; cyc < 8000 && got_b < n; cyc++) begin
      if (!slv_awvalid && sent_aw < n && $urandom_range(1, 0) == 1) begin
        slv_awvalid = 1'b1; slv_awaddr = $urandom; slv_awid = 8'($urandom); slv_awprot = 3'($urandom);
      end
      if (!slv_wvalid && sent_w < n && $urandom_range(1, 0) == 1) begin
        slv_wvalid = 1'b1; slv_wdata = $urandom; slv_wstrb = 4'($urandom);
      end
      mst_awready = 1'($urandom);
      mst_wready  = 1'($urandom);
      slv_bready  = 1'($urandom);
      if (!mst_bvalid && bpend.size() > 0 && $urandom_range(2, 0) != 0) begin
        mst_bvalid = 1'b1; mst_bid = bpend[0]; mst_bresp = 2'($urandom);
      end
      #1;
      hs_aw = slv_awvalid && slv_awready;
      hs_w  = slv_wvalid && slv_wready;
      hs_mb = mst_bvalid && mst_bready;
      hs_sb = slv_bvalid && slv_bready;
      if (ostd >= 4) chk("rnd_sat_awready", slv_awready, 1'b0);
      if (hs_aw) begin
        a = '{addr: slv_awaddr, id: slv_awid, prot: slv_awprot};
        exp_aw.push_back(a); aw_for_w.push_back(a); sent_aw++; ostd++;
      end
      if (hs_w) begin
        exp_w.push_back('{data: slv_wdata, strb: slv_wstrb}); sent_w++;
      end
      if (mst_awvalid && mst_awready) begin
        if (exp_aw.size() == 0) chk("rnd_aw_spurious", 1'b1, 1'b0);
        else begin
          a = exp_aw.pop_front();
          chk("rnd_awaddr", mst_awaddr, a.addr);
          chk("rnd_awid", mst_awid, a.id);
          chk("rnd_awprot", mst_awprot, a.prot);
          mids.push_back(mst_awid);
        end
      end
      if (mst_wvalid && mst_wready) begin
        if (exp_w.size() == 0 || aw_for_w.size() == 0) chk("rnd_w_spurious", 1'b1, 1'b0);
        else begin
          a = aw_for_w.pop_front();
          w = exp_w.pop_front();
          ed = {4{w.data}};
          es = 16'(w.strb) << (4 * ((a.addr / 4) % 4));
          chk("rnd_wdata", mst_wdata, ed);
          chk("rnd_wstrb", mst_wstrb, es);
          chk("rnd_wlast", mst_wlast, 1'b1);
          wdone++;
        end
      end
      while (mids.size() > 0 && wdone > 0) begin
        bpend.push_back(mids.pop_front());
        wdone--;
      end
      if (hs_mb) begin
        bexp.push_back({mst_bid, mst_bresp});
        void'(bpend.pop_front());
      end
      if (hs_sb) begin
        if (bexp.size() == 0) chk("rnd_b_spurious", 1'b1, 1'b0);
        else begin
          be = bexp.pop_front();
          chk("rnd_bid", slv_bid, be[9:2]);
          chk("rnd_bresp", slv_bresp, be[1:0]);
        end
        got_b++; ostd--;
      end
      tick();
      if (hs_aw) slv_awvalid = 1'b0;
      if (hs_w)  slv_wvalid = 1'b0;
      if (hs_mb) mst_bvalid = 1'b0;
    end
    chk("rnd_complete", got_b, n);
  endtask

  initial begin
    aresetn = 1'b0;
    do_reset();

    // reset state
    chk("rst_mst_awvalid", mst_awvalid, 1'b0);
    chk("rst_mst_wvalid", mst_wvalid, 1'b0);
    chk("rst_slv_bvalid", slv_bvalid, 1'b0);
    chk("rst_slv_awready", slv_awready, 1'b1);
    chk("rst_slv_wready", slv_wready, 1'b1);
    chk("rst_mst_bready", mst_bready, 1'b1);
    chk("rst_mst_awaddr", mst_awaddr, 32'h0);
    chk("rst_mst_wdata", mst_wdata, 128'h0);
    chk("rst_mst_wstrb", mst_wstrb, 16'h0);
    chk("rst_slv_bid", slv_bid, 8'h0);

    // equal-width instance: strobes and data pass through
    n_slv_awvalid = 1'b1; n_slv_awaddr = 32'h6;
    n_slv_wvalid = 1'b1; n_slv_wdata = 32'hCAFEF00D; n_slv_wstrb = 4'hC;
    tick();
    n_slv_awvalid = 1'b0; n_slv_wvalid = 1'b0;
    tick();
    chk("n_awvalid", n_mst_awvalid, 1'b1);
    chk("n_awaddr", n_mst_awaddr, 32'h6);
    chk("n_wstrb", n_mst_wstrb, 4'hC);
    chk("n_wdata", n_mst_wdata, 32'hCAFEF00D);
    tick();

    // table-driven single writes, AW and W in the same cycle
    vt[0] = '{32'h0000_1008, 8'h21, 32'hDEADBEEF, 4'hF, 2'd0, {4{32'hDEADBEEF}}, 16'h0F00};
    vt[1] = '{32'h0000_0000, 8'h01, 32'h01020304, 4'h5, 2'd1, {4{32'h01020304}}, 16'h0005};
    vt[2] = '{32'h0000_0004, 8'h02, 32'hA5A5A5A5, 4'h8, 2'd2, {4{32'hA5A5A5A5}}, 16'h0080};
    vt[3] = '{32'hFFFF_FFF7, 8'hFE, 32'h12345678, 4'h3, 2'd3, {4{32'h12345678}}, 16'h0030};
    vt[4] = '{32'h0000_003C, 8'h33, 32'h0000AA00, 4'h2, 2'd0, {4{32'h0000AA00}}, 16'h2000};
    for (int i = 0; i < 5; i++) begin
      set_aw(vt[i].addr, vt[i].id);
      set_w(vt[i].data, vt[i].strb);
      chk("tv_awready", slv_awready, 1'b1);
      tick();
      clr_slv();
      chk("tv_lat1_awvalid", mst_awvalid, 1'b0);
      tick();
      chk("tv_awvalid", mst_awvalid, 1'b1);
      chk("tv_wvalid", mst_wvalid, 1'b1);
      chk("tv_awaddr", mst_awaddr, vt[i].addr);
      chk("tv_awid", mst_awid, vt[i].id);
      chk("tv_wdata", mst_wdata, vt[i].exp_data);
      chk("tv_wstrb", mst_wstrb, vt[i].exp_strb);
      tick();
      chk("tv_out_done", mst_awvalid | mst_wvalid, 1'b0);
      return_b(vt[i].id, vt[i].resp);
    end

    // W arrives three cycles ahead of AW
    set_w(32'h0000AA00, 4'h2);
    tick();
    slv_wvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("wfirst_no_wvalid", mst_wvalid, 1'b0);
      tick();
    end
    set_aw(32'h3C, 8'h34);
    chk("wfirst_no_wvalid", mst_wvalid, 1'b0);
    tick();
    clr_slv();
    chk("wfirst_no_wvalid", mst_wvalid, 1'b0);
    tick();
    chk("wfirst_wvalid", mst_wvalid, 1'b1);
    chk("wfirst_wstrb", mst_wstrb, 16'h2000);
    tick();
    return_b(8'h34, 2'd0);

    // W channel stalled for five cycles while a second request waits
    mst_awready = 1'b1; mst_wready = 1'b0;
    set_aw(32'h10, 8'h41); set_w(32'h11111111, 4'hF);
    tick();
    clr_slv();
    tick();
    chk("stall_awvalid", mst_awvalid, 1'b1);
    chk("stall_wvalid", mst_wvalid, 1'b1);
    set_aw(32'h24, 8'h42); set_w(32'h22222222, 4'hF);
    tick();
    clr_slv();
    for (int k = 0; k < 4; k++) begin
      chk("stall_aw_dropped", mst_awvalid, 1'b0);
      chk("stall_wvalid_hold", mst_wvalid, 1'b1);
      chk("stall_wdata_hold", mst_wdata, {4{32'h11111111}});
      chk("stall_wstrb_hold", mst_wstrb, 16'h000F);
      chk("stall_entry_full", slv_awready, 1'b0);
      tick();
    end
    mst_wready = 1'b1;
    chk("stall_wvalid_last", mst_wvalid, 1'b1);
    tick();
    chk("stall_w_done", mst_wvalid, 1'b0);
    tick();
    chk("stall_2nd_awvalid", mst_awvalid, 1'b1);
    chk("stall_2nd_awaddr", mst_awaddr, 32'h24);
    chk("stall_2nd_wdata", mst_wdata, {4{32'h22222222}});
    chk("stall_2nd_wstrb", mst_wstrb, 16'h00F0);
    tick();
    return_b(8'h41, 2'd0);
    return_b(8'h42, 2'd0);

    // outstanding limit
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_aw(32'(i * 4), 8'(8'h50 + i)); set_w(32'(i), 4'hF);
      tick();
      clr_slv();
      tick();
      tick();
    end
    chk("sat4_awready", slv_awready, 1'b0);
    chk("sat4_wready", slv_wready, 1'b1);
    set_aw(32'h100, 8'h55); set_w(32'h55555555, 4'h1);
    tick();
    slv_wvalid = 1'b0;
    chk("sat_aw_blocked", slv_awready, 1'b0);
    return_b(8'h50, 2'd0);
    chk("sat_release", slv_awready, 1'b1);
    tick();
    slv_awvalid = 1'b0;
    tick();
    chk("sat_5th_awvalid", mst_awvalid, 1'b1);
    chk("sat_5th_awaddr", mst_awaddr, 32'h100);

    // reset while a request is in flight on the master side
    do_reset();
    set_aw(32'h200, 8'h61); set_w(32'h61616161, 4'hF);
    tick();
    clr_slv();
    tick();
    tick();
    mst_awready = 1'b0; mst_wready = 1'b0;
    set_aw(32'h204, 8'h62); set_w(32'h62626262, 4'hF);
    tick();
    clr_slv();
    tick();
    chk("mrst_pre_awvalid", mst_awvalid, 1'b1);
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    chk("mrst_awvalid", mst_awvalid, 1'b0);
    chk("mrst_wvalid", mst_wvalid, 1'b0);
    chk("mrst_bvalid", slv_bvalid, 1'b0);
    chk("mrst_awready", slv_awready, 1'b1);
    chk("mrst_wready", slv_wready, 1'b1);
    chk("mrst_awaddr", mst_awaddr, 32'h0);
    mst_awready = 1'b1; mst_wready = 1'b1;
    tick();
    tick();
    chk("mrst_no_reissue", mst_awvalid | mst_wvalid, 1'b0);

    // randomized traffic against the scoreboard
    do_reset();
    run_random(80);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
